// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the multiply-datapath sequencer.
// Combinational definitions only; no latency, no flow control.
package mul_seq_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 63;
    localparam int DEF_CNT_W   = 6;

    localparam logic [2:0] INS_NOP = 3'b000;
    localparam logic [2:0] INS_MUL = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_DR,
        S_LOAD_MQ,
        S_CLR_ACC,
        S_ISSUE,
        S_WAIT,
        S_READ_ACC,
        S_READ_MQ,
        S_DONE
    } state_t;

endpackage

// File: rtl/mul_seq_timer.sv
// Clearable, enabled up-counter with a terminal-count flag at TIMEOUT-1.
// Count updates one cycle after clear/enable; no backpressure.
module mul_seq_timer #(
    parameter int TIMEOUT = 63,
    parameter int CNT_W   = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mul_seq_driver.sv
// Sequences one multiply transaction on the Acc/MQ/DR datapath: load, issue, wait, read back.
// done at cycle 7+w after start (w = WAIT cycles until RDY); start ignored while busy.
module mul_seq_driver
    import mul_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2*WIDTH-1:0] result,
    input  logic               dp_RDY,
    input  logic [WIDTH-1:0]   dp_outBUS,
    output logic [2:0]         dp_INS,
    output logic [WIDTH-1:0]   dp_inBUS,
    output logic               dp_LDDR,
    output logic               dp_LDMQ,
    output logic               dp_LDAcc,
    output logic               dp_STDR,
    output logic               dp_STMQ,
    output logic               dp_STAcc,
    output logic               dp_TESTMODE
);

    state_t           state;
    state_t           nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             tc;

    mul_seq_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == S_ISSUE),
        .enable (state == S_WAIT),
        .tc     (tc)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:     nxt = start ? S_LOAD_DR : S_IDLE;
            S_LOAD_DR:  nxt = S_LOAD_MQ;
            S_LOAD_MQ:  nxt = S_CLR_ACC;
            S_CLR_ACC:  nxt = S_ISSUE;
            S_ISSUE:    nxt = S_WAIT;
            // RDY takes priority over a simultaneous timeout
            S_WAIT:     nxt = dp_RDY ? S_READ_ACC : (tc ? S_DONE : S_WAIT);
            S_READ_ACC: nxt = S_READ_MQ;
            S_READ_MQ:  nxt = S_DONE;
            S_DONE:     nxt = S_IDLE;
            default:    nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state they belong to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= INS_NOP;
            a_q      <= '0;
            b_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
            dp_INS   <= INS_NOP;
            dp_LDDR  <= 1'b0;
            dp_LDMQ  <= 1'b0;
            dp_LDAcc <= 1'b0;
            dp_STMQ  <= 1'b0;
            dp_STAcc <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && start) begin
                op_q <= op;
                a_q  <= operand_a;
                b_q  <= operand_b;
            end
            busy     <= (nxt != S_IDLE);
            done     <= (nxt == S_DONE);
            dp_LDDR  <= (nxt == S_LOAD_DR);
            dp_LDMQ  <= (nxt == S_LOAD_MQ);
            dp_LDAcc <= (nxt == S_CLR_ACC);
            dp_STAcc <= (nxt == S_READ_ACC);
            dp_STMQ  <= (nxt == S_READ_MQ);
            dp_INS   <= (nxt == S_ISSUE || nxt == S_WAIT) ? op_q : INS_NOP;
            if (state == S_READ_ACC) begin
                result[2*WIDTH-1:WIDTH] <= dp_outBUS;
            end
            if (state == S_READ_MQ) begin
                result[WIDTH-1:0] <= dp_outBUS;
            end
            // DONE is entered straight from WAIT only on timeout
            if (nxt == S_DONE) begin
                err <= (state == S_WAIT);
            end
        end
    end

    // Write bus is steered by the registered load strobes; zero when none is active.
    always_comb begin
        dp_inBUS = '0;
        if (dp_LDDR) begin
            dp_inBUS = a_q;
        end else if (dp_LDMQ) begin
            dp_inBUS = b_q;
        end
    end

    assign dp_STDR     = 1'b0;
    assign dp_TESTMODE = 1'b0;

endmodule

// File: tb/tb_mul_seq_driver.sv
// Directed and randomized transactions against a cycle-table model of the sequencer.
module tb_mul_seq_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] result;
    logic        dp_RDY;
    logic [7:0]  dp_outBUS;
    logic [2:0]  dp_INS;
    logic [7:0]  dp_inBUS;
    logic        dp_LDDR, dp_LDMQ, dp_LDAcc, dp_STDR, dp_STMQ, dp_STAcc, dp_TESTMODE;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_result;
    logic        exp_err;
    logic [7:0]  acc_v;
    logic [7:0]  mq_v;

    always #5 clock = ~clock;

    // Datapath read-back model: each store strobe exposes its register value.
    assign dp_outBUS = dp_STAcc ? acc_v : (dp_STMQ ? mq_v : 8'h00);

    mul_seq_driver dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .result      (result),
        .dp_RDY      (dp_RDY),
        .dp_outBUS   (dp_outBUS),
        .dp_INS      (dp_INS),
        .dp_inBUS    (dp_inBUS),
        .dp_LDDR     (dp_LDDR),
        .dp_LDMQ     (dp_LDMQ),
        .dp_LDAcc    (dp_LDAcc),
        .dp_STDR     (dp_STDR),
        .dp_STMQ     (dp_STMQ),
        .dp_STAcc    (dp_STAcc),
        .dp_TESTMODE (dp_TESTMODE)
    );

    function automatic logic [19:0] outs();
        return {busy, done, dp_LDDR, dp_LDMQ, dp_LDAcc, dp_STDR, dp_STMQ, dp_STAcc,
                dp_TESTMODE, dp_INS, dp_inBUS};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // w = WAIT cycle in which RDY is shown (0 = never, forcing a timeout)
    task automatic run_txn(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                           input int w, input logic [7:0] acc, input logic [7:0] mq,
                           input bit hold, input bit stray);
        bit          to;
        int          last;
        int          nwait;
        logic [2:0]  e_ins;
        logic [7:0]  e_bus;
        logic [19:0] e_vec;
        to    = (w == 0);
        nwait = to ? 63 : w;
        last  = to ? 68 : 7 + w;
        check("idle_before", {12'h0, outs()}, 32'h0);
        check("held_result", {15'h0, err, result}, {15'h0, exp_err, exp_result});
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        acc_v     = acc;
        mq_v      = mq;
        dp_RDY    = 1'b0;
        @(posedge clock); #1;
        if (!hold) start = 1'b0;
        for (int k = 1; k <= last; k++) begin
            dp_RDY = (!to && k == 4 + w);
            if (stray && k == 4) begin start = 1'b1; operand_a = 8'hFF; end
            if (stray && k == 5) start = 1'b0;
            if (stray && k == last) start = 1'b1;
            e_ins = (k >= 4 && k <= 4 + nwait) ? o : 3'b000;
            e_bus = (k == 1) ? a : ((k == 2) ? b : 8'h00);
            e_vec = {1'b1, (k == last), (k == 1), (k == 2), (k == 3), 1'b0,
                     (!to && k == 6 + w), (!to && k == 5 + w), 1'b0, e_ins, e_bus};
            check($sformatf("cycle%0d_w%0d", k, w), {12'h0, outs()}, {12'h0, e_vec});
            if (k == last) begin
                if (!to) exp_result = {acc, mq};
                exp_err = to;
                check("done_result", {15'h0, err, result}, {15'h0, exp_err, exp_result});
            end
            @(posedge clock); #1;
        end
        dp_RDY = 1'b0;
        if (!hold) start = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        op         = 3'b000;
        operand_a  = 8'h00;
        operand_b  = 8'h00;
        dp_RDY     = 1'b0;
        acc_v      = 8'h00;
        mq_v       = 8'h00;
        exp_result = 16'h0000;
        exp_err    = 1'b0;
        #2;
        check("reset_outs", {12'h0, outs()}, 32'h0);
        check("reset_result", {15'h0, err, result}, 32'h0);
        #10 reset = 1'b0;
        @(posedge clock); #1;

        // nominal
        run_txn(3'b100, 8'h0D, 8'h0B, 3, 8'h12, 8'h34, 1'b0, 1'b0);
        // timeout: result must survive
        run_txn(3'b100, 8'h21, 8'h43, 0, 8'hEE, 8'hEE, 1'b0, 1'b0);
        // start pulses while busy and during DONE
        run_txn(3'b010, 8'h5A, 8'hC3, 2, 8'h9E, 8'h71, 1'b0, 1'b1);

        // reset in the middle of WAIT
        start     = 1'b1;
        op        = 3'b100;
        operand_a = 8'h77;
        operand_b = 8'h66;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clock); #1; end
        #2 reset = 1'b1;
        #1;
        check("reset_async", {12'h0, outs()}, 32'h0);
        #2 reset = 1'b0;
        exp_result = 16'h0000;
        exp_err    = 1'b0;
        @(posedge clock); #1;
        check("after_reset_idle", {12'h0, outs()}, 32'h0);
        run_txn(3'b100, 8'h13, 8'h57, 1, 8'hBE, 8'hEF, 1'b0, 1'b0);

        // back-to-back with start held
        run_txn(3'b100, 8'h01, 8'h02, 1, 8'hAA, 8'h55, 1'b1, 1'b0);
        run_txn(3'b100, 8'h03, 8'h04, 1, 8'h55, 8'hAA, 1'b1, 1'b0);
        run_txn(3'b100, 8'h05, 8'h06, 1, 8'hAA, 8'h55, 1'b0, 1'b0);

        // RDY coincides with terminal count
        run_txn(3'b100, 8'h31, 8'h42, 63, 8'hC0, 8'hDE, 1'b0, 1'b0);

        // randomized transactions
        for (int i = 0; i < 8; i++) begin
            run_txn(3'($urandom_range(7, 0)), 8'($urandom), 8'($urandom),
                    int'($urandom_range(8, 1)), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        end

        repeat (3) begin
            @(posedge clock); #1;
            check("final_idle", {12'h0, outs()}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_seq_driver.md
Name: mul_seq_driver

Overview:
- Bus-side sequencer (initiator) for the 8-bit Acc/MQ/DR shift-add multiply datapath.
- Accepts one operation request from a host and performs the full transaction:
  - load DR, then MQ, then clear Acc;
  - present INS and wait for RDY;
  - read Acc and MQ back over the shared output bus.
- Presents the 16-bit result {Acc,MQ} with a done pulse. Sits between the host control logic and the datapath strobe/bus pins. Drives TESTMODE low permanently.

Parameters:
- WIDTH, 8, datapath register / bus width.
- TIMEOUT, 63, max cycles spent in WAIT before aborting with err.
- CNT_W, 6, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  host request; sampled only in IDLE.
- op  in  3  instruction code forwarded to INS.
- operand_a  in  WIDTH  value loaded into DR.
- operand_b  in  WIDTH  value loaded into MQ.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, result/err valid.
- err  out  1  timeout flag, valid with done; held until next done.
- result  out  2*WIDTH  {Acc,MQ} captured; held until next done.
- dp_RDY  in  1  datapath ready.
- dp_outBUS  in  WIDTH  datapath read bus.
- dp_INS  out  3  instruction to datapath.
- dp_inBUS  out  WIDTH  write bus to datapath.
- dp_LDDR, dp_LDMQ, dp_LDAcc  out  1 each  load strobes.
- dp_STDR, dp_STMQ, dp_STAcc  out  1 each  read strobes.
- dp_TESTMODE  out  1  constant 0.

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; result=0; err=0; timeout counter=0. Reset mid-transaction abandons it immediately; no done is issued.
- States: IDLE, LOAD_DR, LOAD_MQ, CLR_ACC, ISSUE, WAIT, READ_ACC, READ_MQ, DONE.
- Request capture: on a clock edge in IDLE with start=1, latch op, operand_a and operand_b into internal registers, then go to LOAD_DR. Host inputs are not re-sampled until the next IDLE.
- LOAD_DR (1 cycle): dp_LDDR=1, dp_inBUS=operand_a.
- LOAD_MQ (1 cycle): dp_LDMQ=1, dp_inBUS=operand_b.
- CLR_ACC (1 cycle): dp_LDAcc=1, dp_inBUS=0.
- ISSUE (1 cycle): dp_INS=op; clear timeout counter.
- WAIT:
  - dp_INS held at op; counter increments each cycle.
  - dp_RDY=1 → READ_ACC (minimum 1 WAIT cycle).
  - Else if counter==TIMEOUT-1 → DONE with err=1; result is not updated.
  - RDY and timeout in the same cycle: RDY wins.
- READ_ACC (1 cycle): dp_STAcc=1; result[2W-1:W] <= dp_outBUS at the end of the cycle.
- READ_MQ (1 cycle): dp_STMQ=1; result[W-1:0] <= dp_outBUS at the end of the cycle.
- DONE (1 cycle): done=1; err is updated on entry (1 on timeout, 0 otherwise); next state IDLE. A start asserted during DONE is ignored.
- Strobe rules:
  - Exactly one of the six LD/ST strobes is high in LOAD_*/CLR_ACC/READ_* states; none in any other state.
  - dp_inBUS=0 whenever no LD strobe is high.
  - dp_INS=0 outside ISSUE/WAIT.
  - dp_STDR is never asserted (reserved; tied 0).
- Latency: with start sampled at edge 0 and RDY first seen in WAIT cycle w (w≥1), done is high in cycle 7+w.
- Back-to-back: start may be held high; the next transaction is accepted in the first IDLE cycle after DONE.

Decomposition:
- Shared package mul_seq_pkg holds:
  - state enum;
  - INS opcode constants;
  - default WIDTH and TIMEOUT localparams.
- One natural sub-module, mul_seq_timer: clearable, enabled counter with a terminal-count flag. Everything else stays in one FSM.

Test Plan:
- Nominal: op=3'b100, a=0x0D, b=0x0B; model holds RDY high in the 3rd WAIT cycle and drives 0x12 on STAcc, 0x34 on STMQ → strobes in cycles 1/2/3/8/9 exactly as specified, done in cycle 10, result=0x1234, err=0.
- Timeout: RDY never asserted → done in cycle 5+63=68, err=1, result keeps its previous value, no ST strobe asserted.
- Reset mid-WAIT: assert reset in cycle 6 → all strobes/busy drop asynchronously in that cycle; no done; next start runs cleanly from LOAD_DR.
- Start while busy: pulse start with a=0xFF in cycle 4 → ignored; LOAD_DR drove the original operand; exactly one done.
- Back-to-back: start held high, RDY immediate → done every 9 cycles; results alternate with model values 0xAA55/0x55AA.
- RDY at terminal count: RDY asserted in the same cycle as counter==TIMEOUT-1 → READ_ACC path taken, err=0.
